// File: rtl/exe_mul_seq.sv
// exe_mul_seq: multi-cycle shift-add multiplier beside the execute stage.
// Takes one WIDTH x WIDTH multiply (signed or unsigned) and retires one
// multiplier bit per cycle. It holds the pipeline front while busy and gives a
// 2*WIDTH product with a one-cycle done strobe.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   start      multiply request, accepted only in IDLE or DONE
//   signed_op  1 = two's-complement operands, 0 = unsigned
//   opA        multiplicand
//   opB        multiplier
//   flush      abort the operation in flight; wins over start
//   stall      combinational hold request for upstream stages
//   busy       operation in flight (RUN or FIX), registered
//   done       one-cycle strobe, product valid, registered
//   prod_lo    product bits [WIDTH-1:0]
//   prod_hi    product bits [2*WIDTH-1:WIDTH]
module exe_mul_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic             neg;

  logic             in_run_fix;
  logic             can_accept;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] addend;
  logic [SW-1:0]    sum;
  logic [PW-1:0]    full;
  logic [PW-1:0]    fixed;
  logic             last_iter;

  // Operand magnitudes; 0x8000 maps onto itself and is fine as an unsigned value
  always_comb begin
    mag_a = opA;
    mag_b = opB;
    if (signed_op && opA[WIDTH-1]) mag_a = WIDTH'(~opA + WIDTH'(1));
    if (signed_op && opB[WIDTH-1]) mag_b = WIDTH'(~opB + WIDTH'(1));
  end

  // One iteration: conditional add into the upper half, carry kept for the shift
  always_comb begin
    addend    = mplier[0] ? mcand : '0;
    sum       = SW'({1'b0, acc}) + SW'({1'b0, addend});
    full      = {acc, mplier};
    fixed     = neg ? PW'(~full + PW'(1)) : full;
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  assign in_run_fix = (state == RUN) || (state == FIX);
  assign can_accept = (state == IDLE) || (state == DONE);
  assign stall      = (start && !flush && can_accept) || in_run_fix;

  // Sequencer and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      prod_lo <= '0;
      prod_hi <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              mcand  <= mag_a;
              mplier <= mag_b;
              acc    <= '0;
              neg    <= signed_op && (opA[WIDTH-1] ^ opB[WIDTH-1]);
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              state <= IDLE;
            end
          end
          RUN: begin
            // shift {carry, acc, multiplier} right by one
            acc    <= sum[SW-1:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) state <= FIX;
          end
          FIX: begin
            prod_hi <= fixed[PW-1:WIDTH];
            prod_lo <= fixed[WIDTH-1:0];
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
